// File: rtl/spi_shift_engine_if.sv
// rtl/spi_shift_engine_if.sv - register-side and strobe-side signal bundle for the SPI shift engine
interface spi_shift_engine_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             lsb_first;
    logic             cpha;
    logic             sample_en;
    logic             shift_en;
    logic             abort;
    logic             s_in;
    logic             s_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;

    modport master (
        output load, data_in, lsb_first, cpha, sample_en, shift_en, abort, s_in,
        input  s_out, busy, done, rx_data
    );

    modport slave (
        input  load, data_in, lsb_first, cpha, sample_en, shift_en, abort, s_in,
        output s_out, busy, done, rx_data
    );
endinterface

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - parametrised full-duplex SPI shift engine with selectable bit order and phase
module spi_shift_engine #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    spi_shift_engine_if.slave  bus
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  tx_q;
    logic [WIDTH-1:0]  rx_sh_q;
    logic [WIDTH-1:0]  rx_data_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              lsb_q;
    logic              skip_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  tx_shift_d;
    logic [WIDTH-1:0]  rx_shift_d;
    logic              last_sample_d;

    always_comb begin
        tx_shift_d    = lsb_q ? {1'b0, tx_q[WIDTH-1:1]} : {tx_q[WIDTH-2:0], 1'b0};
        rx_shift_d    = lsb_q ? {bus.s_in, rx_sh_q[WIDTH-1:1]} : {rx_sh_q[WIDTH-2:0], bus.s_in};
        last_sample_d = bus.sample_en && (bit_cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            lsb_q     <= 1'b0;
            skip_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        tx_q      <= bus.data_in;
                        rx_sh_q   <= '0;
                        bit_cnt_q <= '0;
                        lsb_q     <= bus.lsb_first;
                        // cpha=1 launches on the leading edge, which must not consume bit 0
                        skip_q    <= bus.cpha;
                        state_q   <= S_ACTIVE;
                        busy_q    <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (bus.abort) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        skip_q    <= 1'b0;
                    end else begin
                        if (bus.shift_en) begin
                            if (skip_q) begin
                                skip_q <= 1'b0;
                            end else begin
                                tx_q <= tx_shift_d;
                            end
                        end
                        if (bus.sample_en) begin
                            rx_sh_q <= rx_shift_d;
                            if (last_sample_d) begin
                                rx_data_q <= rx_shift_d;
                                done_q    <= 1'b1;
                                state_q   <= S_IDLE;
                                busy_q    <= 1'b0;
                                bit_cnt_q <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // busy_q gates the output so MOSI idles low regardless of leftover tx bits
    assign bus.s_out   = busy_q & (lsb_q ? tx_q[0] : tx_q[WIDTH-1]);
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
Parametrised full-duplex SPI shift engine, successor to the fixed 8-bit transmit-only shifter.
- Width is configurable; bit order and clock phase are selectable per transfer.
- Transmits and receives simultaneously, counts bits, and reports completion.
- Sits between the SPI clock generator, which supplies one-cycle edge strobes, and the master's register interface.

Parameters:
WIDTH, 8, transfer word length in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
load  input  1  start-transfer request; honoured only in IDLE.
data_in  input  WIDTH  transmit word; captured on an accepted load.
lsb_first  input  1  bit order (0 = MSB first); latched on an accepted load.
cpha  input  1  clock phase; latched on an accepted load.
sample_en  input  1  one-cycle strobe at each SCK sampling edge.
shift_en  input  1  one-cycle strobe at each SCK launching edge.
abort  input  1  cancels the current transfer.
s_in  input  1  MISO, already synchronised.
s_out  output  1  MOSI bit.
busy  output  1  high while a transfer is in progress.
done  output  1  one-cycle pulse when a transfer completes.
rx_data  output  WIDTH  last completely received word.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; tx_reg, rx_sh, rx_data and bit_cnt = 0.
  - s_out=0, busy=0, done=0.
  - Reset wins over every other input, including mid-transfer; no done is produced.
- States: IDLE and ACTIVE.
- busy is registered and equals (state==ACTIVE).
- IDLE:
  - s_out=0; strobes and abort are ignored.
  - load=1: tx_reg<=data_in, rx_sh<=0, bit_cnt<=0, latch lsb_first and cpha, skip<=cpha, state<=ACTIVE.
  - s_out is valid the cycle after load (busy=1 in that same cycle).
- ACTIVE:
  - load is ignored; data_in is not recaptured.
  - s_out = tx_reg[WIDTH-1] when MSB first, tx_reg[0] when LSB first. It is combinational from tx_reg and the latched mode.
- shift_en in ACTIVE:
  - If skip=1: clear skip, leave tx_reg unchanged. This suppresses the CPHA=1 leading edge so the first bit is not lost.
  - Otherwise shift tx_reg one place away from the output end, zero-filling. MSB first: {tx_reg[WIDTH-2:0],0}. LSB first: {0,tx_reg[WIDTH-1:1]}.
- sample_en in ACTIVE:
  - Shift s_in into rx_sh. MSB first: {rx_sh[WIDTH-2:0],s_in}. LSB first: {s_in,rx_sh[WIDTH-1:1]}.
  - bit_cnt<=bit_cnt+1.
- Completion:
  - Occurs on the sample_en for which bit_cnt==WIDTH-1.
  - Next cycle: rx_data = final word including that bit, done=1 for exactly one cycle, state=IDLE, busy=0, bit_cnt=0.
- Simultaneous sample_en and shift_en: both take effect in the same cycle. Sample uses the current s_in; shift uses the pre-edge tx_reg.
- A shift_en arriving together with the completing sample is still applied, but is irrelevant because the engine returns to IDLE.
- Trailing strobes after completion fall in IDLE and are ignored.
- abort in ACTIVE: state<=IDLE, busy<=0, no done, rx_data unchanged, s_out<=0. If abort coincides with the completing sample, abort wins.
- load and abort in the same IDLE cycle: load is accepted.
- A new load is accepted in the cycle done is high, because the state is already IDLE.
- rx_data changes only on completion or reset.
- bit_cnt never exceeds WIDTH-1 while ACTIVE.

Test Plan:
1. WIDTH=8, lsb_first=0, cpha=0, load 0xA5. Issue 8 sample/shift pairs, sample first each pair, with s_in sequence 0,0,1,1,1,1,0,0. Required: s_out = 1,0,1,0,0,1,0,1; rx_data=0x3C; done high exactly one cycle; busy falls that cycle.
2. Same stimulus with lsb_first=1, load 0xA5, s_in 0,0,1,1,1,1,0,0. Required: s_out = 1,0,1,0,0,1,0,1 (LSB first); rx_data=0x3C.
3. cpha=1, load 0x81, shift before each sample (8 shifts, 8 samples). Required: first shift suppressed; s_out at the 8 samples = 1,0,0,0,0,0,0,1; done after the 8th sample.
4. Load 0xFF, then abort after 3 samples. Required: no done, busy=0 next cycle, rx_data keeps its previous value. A load of 0x5A while busy (before the abort) must be ignored, and the transferred bits must still come from 0xFF.
5. rst asserted after 4 of 8 bits. Required: next cycle all outputs are 0. A following full transfer of 0x3C completes normally with the correct rx_data.
6. WIDTH=16, load 0xBEEF, loop s_out back to s_in, MSB first. Required: rx_data=0xBEEF after 16 samples; done pulses once; a back-to-back load in the done cycle starts a second transfer.
